bmu_multicycle: RTL and testbench



---
 rtl/bmu_multicycle_pkg.sv | 40 ++++
 rtl/bmu_mc_step.sv | 60 ++++++
 rtl/bmu_multicycle.sv | 173 +++++++++++++++++
 tb/tb_bmu_multicycle.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bmu_multicycle_pkg.sv
// Shared definitions for the bit-manipulation units: option codes, FSM
// encoding, operation classes and the STEP-derived base latency.
package bmu_multicycle_pkg;

    localparam logic [4:0] OPT_CLMUL  = 5'b00001;
    localparam logic [4:0] OPT_CLMULH = 5'b00010;
    localparam logic [4:0] OPT_CLMULR = 5'b00011;
    localparam logic [4:0] OPT_CLZ    = 5'b00100;
    localparam logic [4:0] OPT_CPOP   = 5'b00101;
    localparam logic [4:0] OPT_CTZ    = 5'b00110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        CLS_NONE  = 3'd0,
        CLS_CLMUL = 3'd1,
        CLS_CLZ   = 3'd2,
        CLS_CTZ   = 3'd3,
        CLS_CPOP  = 3'd4
    } op_cls_e;

    function automatic int bmu_lat(input int step);
        return 32 / step;
    endfunction

    function automatic op_cls_e bmu_op_class(input logic [4:0] op);
        case (op)
            OPT_CLMUL, OPT_CLMULH, OPT_CLMULR: return CLS_CLMUL;
            OPT_CLZ:                           return CLS_CLZ;
            OPT_CTZ:                           return CLS_CTZ;
            OPT_CPOP:                          return CLS_CPOP;
            default:                           return CLS_NONE;
        endcase
    endfunction

endpackage

// File: rtl/bmu_mc_step.sv
// One iteration of the multi-cycle unit: folds a STEP-bit chunk into the
// carry-less product or the running count.
module bmu_mc_step
    import bmu_multicycle_pkg::*;
#(
    parameter int STEP = 1
) (
    input  op_cls_e          cls_i,
    input  logic [STEP-1:0]  chunk_i,
    input  logic [5:0]       pos_i,
    input  logic [31:0]      x_i,
    input  logic [63:0]      p_i,
    input  logic [5:0]       cnt_i,
    input  logic             found_i,
    output logic [63:0]      p_o,
    output logic [5:0]       cnt_o,
    output logic             found_o
);

    always_comb begin
        p_o     = p_i;
        cnt_o   = cnt_i;
        found_o = found_i;
        case (cls_i)
            CLS_CLMUL: begin
                for (int j = 0; j < STEP; j++) begin
                    if (chunk_i[j]) begin
                        p_o = p_o ^ ({32'd0, x_i} << (pos_i + 6'(j)));
                    end
                end
            end
            CLS_CPOP: begin
                for (int j = 0; j < STEP; j++) begin
                    cnt_o = cnt_o + {5'd0, chunk_i[j]};
                end
            end
            CLS_CTZ: begin
                for (int j = 0; j < STEP; j++) begin
                    if (!found_o) begin
                        if (chunk_i[j]) found_o = 1'b1;
                        else            cnt_o   = cnt_o + 6'd1;
                    end
                end
            end
            CLS_CLZ: begin
                // CLZ chunks arrive MSB-aligned, so scan from the top bit down
                for (int j = 0; j < STEP; j++) begin
                    if (!found_o) begin
                        if (chunk_i[STEP-1-j]) found_o = 1'b1;
                        else                   cnt_o   = cnt_o + 6'd1;
                    end
                end
            end
            default: begin
                p_o = p_i;
            end
        endcase
    end

endmodule

// File: rtl/bmu_multicycle.sv
// Iterative CLMUL/CLMULH/CLMULR/CLZ/CPOP/CTZ unit, STEP bits per cycle.
// Define BMU_EARLY_EXIT_EN to leave RUN as soon as no work remains.
//
// state   | meaning
// IDLE    | waiting for start, result held
// RUN     | consuming STEP bits per cycle, busy=1
// DONE    | one-cycle done pulse, result valid
module bmu_multicycle
    import bmu_multicycle_pkg::*;
#(
    parameter int STEP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [4:0]  option,
    input  logic [31:0] BMU_in_X,
    input  logic [31:0] BMU_in_Y,
    output logic        busy,
    output logic        done,
    output logic [31:0] BMU_out_S
);

    localparam int         LAT   = bmu_lat(STEP);
    localparam logic [5:0] LAT6  = 6'(LAT);
    localparam logic [5:0] STEP6 = 6'(STEP);

    if (STEP != 1 && STEP != 2 && STEP != 4 && STEP != 8) begin : g_bad_step
        $error("bmu_multicycle: STEP must be 1, 2, 4 or 8");
    end

    state_e      state_q, state_d;
    logic [4:0]  op_q, op_d;
    logic [31:0] x_q, x_d;
    logic [31:0] y_q, y_d;
    logic [63:0] p_q, p_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        found_q, found_d;
    logic [5:0]  ctr_q, ctr_d;
    logic [31:0] out_q, out_d;

    op_cls_e         cls;
    logic [5:0]      pos;
    logic [31:0]     src;
    logic [STEP-1:0] chunk;
    logic [63:0]     step_p;
    logic [5:0]      step_cnt;
    logic            step_found;
    logic [31:0]     res;
    logic            early;

    assign cls = bmu_op_class(op_q);
    // Counter runs LAT..1, so the chunk index is LAT minus the counter
    assign pos = (LAT6 - ctr_q) * STEP6;
    assign src = (cls == CLS_CLMUL) ? y_q : x_q;
    assign chunk = (cls == CLS_CLZ) ? STEP'((src << pos) >> (32 - STEP))
                                    : STEP'(src >> pos);

    bmu_mc_step #(.STEP(STEP)) u_step (
        .cls_i   (cls),
        .chunk_i (chunk),
        .pos_i   (pos),
        .x_i     (x_q),
        .p_i     (p_q),
        .cnt_i   (cnt_q),
        .found_i (found_q),
        .p_o     (step_p),
        .cnt_o   (step_cnt),
        .found_o (step_found)
    );

`ifdef BMU_EARLY_EXIT_EN
    logic rest_zero;
    assign rest_zero = ((src >> (pos + STEP6)) == 32'd0);

    always_comb begin
        early = 1'b0;
        case (cls)
            CLS_CLMUL, CLS_CPOP: early = rest_zero;
            CLS_CLZ, CLS_CTZ:    early = step_found;
            default:             early = 1'b0;
        endcase
    end
`else
    assign early = 1'b0;
`endif

    always_comb begin
        res = 32'd0;
        case (op_q)
            OPT_CLMUL:  res = step_p[31:0];
            OPT_CLMULH: res = step_p[63:32];
            OPT_CLMULR: res = step_p[62:31];
            default:    res = {26'd0, step_cnt};
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        x_d     = x_q;
        y_d     = y_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        found_d = found_q;
        ctr_d   = ctr_q;
        out_d   = out_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d    = option;
                    x_d     = BMU_in_X;
                    y_d     = BMU_in_Y;
                    p_d     = 64'd0;
                    cnt_d   = 6'd0;
                    found_d = 1'b0;
                    ctr_d   = LAT6;
                    if (bmu_op_class(option) == CLS_NONE) begin
                        out_d   = 32'd0;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                p_d     = step_p;
                cnt_d   = step_cnt;
                found_d = step_found;
                ctr_d   = ctr_q - 6'd1;
                if (ctr_q == 6'd1 || early) begin
                    out_d   = res;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= 5'd0;
            x_q     <= 32'd0;
            y_q     <= 32'd0;
            p_q     <= 64'd0;
            cnt_q   <= 6'd0;
            found_q <= 1'b0;
            ctr_q   <= 6'd0;
            out_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            x_q     <= x_d;
            y_q     <= y_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            found_q <= found_d;
            ctr_q   <= ctr_d;
            out_q   <= out_d;
        end
    end

    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign BMU_out_S = out_q;

endmodule

// File: tb/tb_bmu_multicycle.sv
// Scoreboard bench for bmu_multicycle: four instances (STEP=1,2,4,8) share
// operands; expected results and done cycles are queued at issue time.
module tb_bmu_multicycle;

    localparam int NI = 4;
    localparam int K_NONE = 0, K_CLMUL = 1, K_CPOP = 2, K_CTZ = 3, K_CLZ = 4;
    localparam logic [4:0] O_CLMUL = 5'b00001, O_CLMULH = 5'b00010, O_CLMULR = 5'b00011;
    localparam logic [4:0] O_CLZ = 5'b00100, O_CPOP = 5'b00101, O_CTZ = 5'b00110;
`ifdef BMU_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef struct packed {
        logic [1:0]  inst;
        logic [31:0] res;
        logic [31:0] issue;
        logic [31:0] due;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic [NI-1:0] start_v;
    logic [4:0]    option;
    logic [31:0]   x_in, y_in;
    logic [NI-1:0] busy_v, done_v;
    logic [31:0]   out_v [NI];

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   busy_cnt [NI];
    exp_t sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        bmu_multicycle #(.STEP(1 << gi)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .start     (start_v[gi]),
            .option    (option),
            .BMU_in_X  (x_in),
            .BMU_in_Y  (y_in),
            .busy      (busy_v[gi]),
            .done      (done_v[gi]),
            .BMU_out_S (out_v[gi])
        );
    end

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst=%0d got=%h want=%h", name, inst, act, exp);
        end
    endtask

    function automatic int kind_of(input logic [4:0] op);
        case (op)
            O_CLMUL, O_CLMULH, O_CLMULR: return K_CLMUL;
            O_CLZ:  return K_CLZ;
            O_CPOP: return K_CPOP;
            O_CTZ:  return K_CTZ;
            default: return K_NONE;
        endcase
    endfunction

    // Cycles from start to done: 1 for unsupported, else RUN length + 1
    function automatic int exp_lat(input int kind, input logic [31:0] x, input logic [31:0] y, input int step);
        int lat;
        int n;
        int hi;
        int lo;
        logic [31:0] s;
        lat = 32 / step;
        n = lat;
        hi = -1;
        lo = -1;
        s = (kind == K_CLMUL) ? y : x;
        for (int b = 0; b < 32; b++) begin
            if (s[b]) begin
                if (lo < 0) lo = b;
                hi = b;
            end
        end
        if (kind == K_NONE) return 1;
        if (EARLY) begin
            case (kind)
                K_CLMUL, K_CPOP: n = (hi < 0) ? 1 : hi / step + 1;
                K_CTZ:           n = (lo < 0) ? lat : lo / step + 1;
                K_CLZ:           n = (hi < 0) ? lat : (31 - hi) / step + 1;
                default:         n = lat;
            endcase
        end
        return n + 1;
    endfunction

    task automatic issue(input logic [NI-1:0] mask, input logic [4:0] op,
                         input logic [31:0] x, input logic [31:0] y, input logic [31:0] res);
        exp_t e;
        option  = op;
        x_in    = x;
        y_in    = y;
        start_v = mask;
        for (int i = 0; i < NI; i++) begin
            if (mask[i]) begin
                e.inst  = 2'(i);
                e.res   = res;
                e.issue = 32'(cyc);
                e.due   = 32'(cyc + exp_lat(kind_of(op), x, y, 1 << i));
                sb.push_back(e);
            end
        end
        @(negedge clk); #1;
        start_v = '0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL timeout pending=%0d want=0", sb.size());
            sb.delete();
        end
        @(negedge clk); #1;
    endtask

    task automatic run(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y, input logic [31:0] res);
        issue('1, op, x, y, res);
        wait_idle();
    endtask

    initial begin
        for (int i = 0; i < NI; i++) busy_cnt[i] = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                for (int i = 0; i < NI; i++) busy_cnt[i] = 0;
            end else begin
                for (int i = 0; i < NI; i++) begin
                    if (busy_v[i]) busy_cnt[i]++;
                    if (done_v[i]) begin
                        int idx;
                        idx = -1;
                        for (int k = 0; k < sb.size(); k++) begin
                            if (idx < 0 && sb[k].inst == 2'(i)) idx = k;
                        end
                        if (idx < 0) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_done inst=%0d got=%h want=no_done", i, out_v[i]);
                        end else begin
                            exp_t e;
                            e = sb[idx];
                            sb.delete(idx);
                            chk("result", i, out_v[i], e.res);
                            chk("done_cycle", i, 32'(cyc), e.due);
                            chk("busy_cycles", i, 32'(busy_cnt[i]), e.due - e.issue - 32'd1);
                            chk("busy_at_done", i, {31'd0, busy_v[i]}, 32'd0);
                        end
                        busy_cnt[i] = 0;
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int target;
        int n;
        rst_n   = 1'b0;
        start_v = '0;
        option  = 5'd0;
        x_in    = 32'd0;
        y_in    = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("rst_busy", i, {31'd0, busy_v[i]}, 32'd0);
            chk("rst_done", i, {31'd0, done_v[i]}, 32'd0);
            chk("rst_out", i, out_v[i], 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk); #1;

        run(O_CLMUL,  32'h0000_0003, 32'h0000_0003, 32'h0000_0005);
        run(O_CLMULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run(O_CLMULR, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
        run(O_CLMUL,  32'h0000_00FF, 32'h0000_0101, 32'h0000_FFFF);
        run(O_CLMULH, 32'h8000_0001, 32'h0000_0002, 32'h0000_0001);
        run(O_CLMULR, 32'h8000_0001, 32'h0000_0002, 32'h0000_0002);
        run(O_CLMUL,  32'h1234_5678, 32'h0000_0001, 32'h1234_5678);
        run(O_CLZ,    32'h0001_0000, 32'h0,         32'd15);
        run(O_CLZ,    32'h0000_0000, 32'h0,         32'd32);
        run(O_CLZ,    32'h8000_0000, 32'h0,         32'd0);
        run(O_CTZ,    32'h0000_0000, 32'h0,         32'd32);
        run(O_CTZ,    32'h0000_0001, 32'h0,         32'd0);
        run(O_CTZ,    32'h0000_0100, 32'h0,         32'd8);
        run(O_CPOP,   32'hFFFF_FFFF, 32'h0,         32'd32);
        run(O_CPOP,   32'h0000_0000, 32'h0,         32'd0);
        run(O_CPOP,   32'h0F0F_0001, 32'h0,         32'd9);
        run(5'b00000, 32'hDEAD_BEEF, 32'h1234_5678, 32'd0);
        run(5'b11111, 32'hDEAD_BEEF, 32'h1234_5678, 32'd0);

        // Starts while busy and in the done cycle must both be ignored
        issue(4'b0001, O_CLMUL, 32'h0000_0003, 32'h8000_0003, 32'h8000_0005);
        target = int'(sb[0].due);
        repeat (5) begin @(negedge clk); #1; end
        option  = O_CPOP;
        x_in    = 32'h0000_FFFF;
        y_in    = 32'h0;
        start_v = 4'b0001;
        repeat (2) begin @(negedge clk); #1; end
        start_v = '0;
        n = 0;
        while (cyc < target && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        chk("done_at_target", 0, {31'd0, done_v[0]}, 32'd1);
        start_v = 4'b0001;
        option  = O_CPOP;
        x_in    = 32'h0000_00FF;
        @(negedge clk); #1;
        start_v = '0;
        wait_idle();
        repeat (40) @(negedge clk);
        #1;

        // Reset in cycle 10 of a CLMUL aborts without a done
        issue(4'b0001, O_CLMUL, 32'h0000_0003, 32'h8000_0003, 32'h8000_0005);
        repeat (9) @(negedge clk);
        #1;
        chk("busy_before_reset", 0, {31'd0, busy_v[0]}, 32'd1);
        sb.delete();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 0, {31'd0, busy_v[0]}, 32'd0);
        chk("mid_rst_done", 0, {31'd0, done_v[0]}, 32'd0);
        chk("mid_rst_out", 0, out_v[0], 32'd0);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        issue(4'b0001, O_CLMUL, 32'h0000_0003, 32'h0000_0003, 32'h0000_0005);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
